// File: rtl/kyber_absorb_framer.sv
// kyber_absorb_framer
//   Frames a Kyber pk/ct word stream into absorb rate blocks for the hash
//   core input FIFO. Message words pass through with zero latency. m_last
//   marks every rate-block boundary. The SHA-3/SHAKE multi-rate pad
//   (PAD_BYTE ... 0x80) is appended after the final message word. The
//   message length comes from a k/mode table or from len_words.
//
// Ports
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_start           begin frame (sampled only in IDLE)
//   i_mode [1:0]      0 pk, 1 ct, 2 custom (i_len_words), 3 reserved
//   i_k [2:0]         Kyber rank 2/3/4, sampled with i_start
//   i_len_words       custom length in words, sampled with i_start, >= 1
//   i_s_valid/i_s_data/o_s_ready   upstream word stream
//   o_m_valid/o_m_data/o_m_last/i_m_ready  hash FIFO word stream
//   o_busy            frame in progress
//   o_done            one-cycle pulse after the final pad word is accepted
//   o_err             one-cycle pulse after a rejected start
//   o_blk_cnt [5:0]   rate blocks emitted in the current/last frame
module kyber_absorb_framer #(
  parameter int          RATE_WORDS = 34,
  parameter logic [7:0]  PAD_BYTE   = 8'h06,
  parameter int          LEN_W      = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [2:0]       i_k,
  input  logic [LEN_W-1:0] i_len_words,
  input  logic             i_s_valid,
  input  logic [31:0]      i_s_data,
  output logic             o_s_ready,
  output logic             o_m_valid,
  output logic [31:0]      o_m_data,
  output logic             o_m_last,
  input  logic             i_m_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [5:0]       o_blk_cnt
);

  localparam int IW = (RATE_WORDS > 2) ? $clog2(RATE_WORDS) : 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(RATE_WORDS - 1);
  localparam logic [IW-1:0] PRE_IDX  = IW'(RATE_WORDS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD_FIRST,
    S_PAD_ZERO,
    S_PAD_LAST,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_words_left;
  logic [IW-1:0]    r_widx;
  logic [5:0]       r_blk_cnt;
  logic             r_err;

  logic [LEN_W-1:0] w_len;
  logic             w_len_ok;
  logic             w_xfer;
  logic             w_start_ok;
  logic             w_start_bad;

  // Message length lookup; w_len_ok low means the start is rejected.
  always_comb begin
    w_len    = '0;
    w_len_ok = 1'b0;
    case (i_mode)
      2'd0: begin
        case (i_k)
          3'd2: begin w_len = LEN_W'(200); w_len_ok = 1'b1; end
          3'd3: begin w_len = LEN_W'(296); w_len_ok = 1'b1; end
          3'd4: begin w_len = LEN_W'(392); w_len_ok = 1'b1; end
          default: ;
        endcase
      end
      2'd1: begin
        case (i_k)
          3'd2: begin w_len = LEN_W'(192); w_len_ok = 1'b1; end
          3'd3: begin w_len = LEN_W'(272); w_len_ok = 1'b1; end
          3'd4: begin w_len = LEN_W'(392); w_len_ok = 1'b1; end
          default: ;
        endcase
      end
      2'd2: begin
        w_len    = i_len_words;
        w_len_ok = (i_len_words != '0);
      end
      default: ;
    endcase
  end

  assign w_start_ok  = (r_state == S_IDLE) && i_start &&  w_len_ok;
  assign w_start_bad = (r_state == S_IDLE) && i_start && !w_len_ok;

  // Output decode and next state. Outputs depend only on state and
  // registered counters (plus pass-through in DATA), so they hold while
  // the FIFO stalls.
  always_comb begin
    w_state_nxt = r_state;
    o_m_valid   = 1'b0;
    o_m_data    = 32'h0;
    o_m_last    = 1'b0;
    o_s_ready   = 1'b0;
    o_done      = 1'b0;

    case (r_state)
      S_DATA: begin
        o_m_valid = i_s_valid;
        o_m_data  = i_s_data;
        o_s_ready = i_m_ready;
        o_m_last  = (r_widx == LAST_IDX);
      end
      S_PAD_FIRST: begin
        o_m_valid = 1'b1;
        if (r_widx == LAST_IDX) begin
          // Single-word pad: start byte and final 0x80 share the word.
          o_m_data = {8'h80, 16'h0, PAD_BYTE};
          o_m_last = 1'b1;
        end else begin
          o_m_data = {24'h0, PAD_BYTE};
        end
      end
      S_PAD_ZERO: begin
        o_m_valid = 1'b1;
      end
      S_PAD_LAST: begin
        o_m_valid = 1'b1;
        o_m_data  = 32'h8000_0000;
        o_m_last  = 1'b1;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: ;
    endcase

    w_xfer = o_m_valid & i_m_ready;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_xfer && (r_words_left == LEN_W'(1))) w_state_nxt = S_PAD_FIRST;
      end
      S_PAD_FIRST: begin
        if (w_xfer) begin
          if (r_widx == LAST_IDX)     w_state_nxt = S_DONE;
          else if (r_widx == PRE_IDX) w_state_nxt = S_PAD_LAST;
          else                        w_state_nxt = S_PAD_ZERO;
        end
      end
      S_PAD_ZERO: begin
        if (w_xfer && (r_widx == PRE_IDX)) w_state_nxt = S_PAD_LAST;
      end
      S_PAD_LAST: begin
        if (w_xfer) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_widx       <= '0;
      r_blk_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_words_left <= w_len;
        r_widx       <= '0;
        r_blk_cnt    <= '0;
      end
      // widx keeps counting through the pad so block boundaries stay
      // aligned to the whole message+pad stream.
      if (w_xfer) begin
        r_widx <= (r_widx == LAST_IDX) ? '0 : r_widx + IW'(1);
        if (o_m_last) r_blk_cnt <= r_blk_cnt + 6'd1;
        if (r_state == S_DATA) r_words_left <= r_words_left - LEN_W'(1);
      end
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_err     = r_err;
  assign o_blk_cnt = r_blk_cnt;

endmodule

// File: tb/tb_kyber_absorb_framer.sv
module tb_kyber_absorb_framer;
  localparam int R = 34;
  localparam logic [7:0] PADB = 8'h06;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_s_valid, i_m_ready;
  logic [1:0]  i_mode;
  logic [2:0]  i_k;
  logic [9:0]  i_len_words;
  logic [31:0] i_s_data;
  logic        o_s_ready, o_m_valid, o_m_last, o_busy, o_done, o_err;
  logic [31:0] o_m_data;
  logic [5:0]  o_blk_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  bit mon_en = 1'b0;

  kyber_absorb_framer #(.RATE_WORDS(R), .PAD_BYTE(PADB), .LEN_W(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_k(i_k),
    .i_len_words(i_len_words), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
    .o_s_ready(o_s_ready), .o_m_valid(o_m_valid), .o_m_data(o_m_data),
    .o_m_last(o_m_last), .i_m_ready(i_m_ready), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_blk_cnt(o_blk_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard: every transfer pops one expected {last,data}.
  always @(negedge i_clk) begin
    if (mon_en && o_m_valid && i_m_ready) begin
      logic [32:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_word: got last=%0b data=%08h, required none", o_m_last, o_m_data);
      end else begin
        e = exp_q.pop_front();
        if ({o_m_last, o_m_data} !== e) begin
          n_err++;
          $display("FAIL stream_word: got last=%0b data=%08h, required last=%0b data=%08h",
                   o_m_last, o_m_data, e[32], e[31:0]);
        end
      end
    end
  end

  // Drives one frame: pushes the reference stream, feeds the message words,
  // optionally stalls both sides and pokes start mid-frame.
  task automatic run_frame(input logic [1:0] md, input logic [2:0] kk, input logic [9:0] lw,
                           input int L, input bit stall, input bit poke,
                           output bit got_done, output int n_errp, output int nblk);
    int pad, tot, s_idx;
    logic [31:0] src[$];
    logic [31:0] w;
    logic lst;
    pad = R - (L % R);
    tot = L + pad;
    nblk = tot / R;
    for (int i = 0; i < tot; i++) begin
      if (i < L) begin
        w = $urandom;
        src.push_back(w);
      end else begin
        w = 32'h0;
        if (i == L) w[7:0] = PADB;
        if (i == tot - 1) w[31] = 1'b1;
      end
      lst = ((i % R) == R - 1);
      exp_q.push_back({lst, w});
    end
    got_done = 1'b0;
    n_errp = 0;
    s_idx = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_mode = md; i_k = kk; i_len_words = lw;
    i_s_valid = 1'b0; i_m_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int c = 0; c < 5000 && !got_done; c++) begin
      i_start = poke && (c == 10 || c == 20);
      i_mode = (c == 20) ? 2'd3 : 2'd2;
      i_len_words = 10'd1;
      i_s_valid = (s_idx < L) && (!stall || $urandom_range(0, 2) != 0);
      i_s_data = (s_idx < L) ? src[s_idx] : $urandom;
      i_m_ready = !stall || ($urandom_range(0, 2) != 0);
      @(negedge i_clk);
      if (o_err) n_errp++;
      if (o_done) got_done = 1'b1;
      if (i_s_valid && o_s_ready) s_idx++;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0; i_s_valid = 1'b0; i_m_ready = 1'b1;
  endtask

  // Common end-of-frame checks, inline per test via this expansion.
  task automatic frame_test(input string nm, input logic [1:0] md, input logic [2:0] kk,
                            input logic [9:0] lw, input int L, input bit stall, input bit poke);
    bit gd; int ne, nb;
    run_frame(md, kk, lw, L, stall, poke, gd, ne, nb);
    @(negedge i_clk);
    n_vec++;
    if (gd !== 1'b1) begin n_err++; $display("FAIL %s done: got %0b, required 1", nm, gd); end
    n_vec++;
    if (o_blk_cnt !== 6'(nb)) begin n_err++; $display("FAIL %s blk_cnt: got %0d, required %0d", nm, o_blk_cnt, nb); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL %s missing_words: got %0d left, required 0", nm, exp_q.size()); end
    exp_q.delete();
    n_vec++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_err++; $display("FAIL %s idle_after: got busy=%0b done=%0b, required 0 0", nm, o_busy, o_done);
    end
    n_vec++;
    if (ne != 0) begin n_err++; $display("FAIL %s err_during_frame: got %0d, required 0", nm, ne); end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_k = 3'd2; i_len_words = 10'd0;
    i_s_valid = 1'b1; i_s_data = 32'hDEAD_BEEF; i_m_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0; i_s_valid = 1'b0;
    @(negedge i_clk);
    n_vec++;
    if ({o_busy, o_done, o_err, o_m_valid, o_m_last, o_s_ready, o_blk_cnt} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b mv=%0b ml=%0b sr=%0b blk=%0d, required all 0",
               o_busy, o_done, o_err, o_m_valid, o_m_last, o_s_ready, o_blk_cnt);
    end
  endtask

  task automatic test_ct_k3_aligned();   frame_test("ct_k3",    2'd1, 3'd3, 10'd0,  272, 1'b0, 1'b0); endtask
  task automatic test_pk_k2();           frame_test("pk_k2",    2'd0, 3'd2, 10'd0,  200, 1'b0, 1'b0); endtask
  task automatic test_custom_33();       frame_test("custom33", 2'd2, 3'd0, 10'd33, 33,  1'b0, 1'b0); endtask
  task automatic test_stalls();          frame_test("ct_k4_stall", 2'd1, 3'd4, 10'd0, 392, 1'b1, 1'b0); endtask
  task automatic test_midframe_start();  frame_test("pk_k3_poke",  2'd0, 3'd3, 10'd0, 296, 1'b0, 1'b1); endtask

  task automatic test_reject();
    logic [1:0] md[3] = '{2'd3, 2'd0, 2'd2};
    logic [2:0] kv[3] = '{3'd2, 3'd5, 3'd3};
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      i_start = 1'b1; i_mode = md[i]; i_k = kv[i]; i_len_words = 10'd0;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      n_vec++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
        n_err++; $display("FAIL reject%0d: got err=%0b busy=%0b, required 1 0", i, o_err, o_busy);
      end
      @(negedge i_clk);
      n_vec++;
      if (o_err !== 1'b0 || o_busy !== 1'b0) begin
        n_err++; $display("FAIL reject%0d_after: got err=%0b busy=%0b, required 0 0", i, o_err, o_busy);
      end
    end
  endtask

  task automatic test_reset_in_pad();
    mon_en = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_mode = 2'd2; i_len_words = 10'd5; i_m_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_s_valid = 1'b1; i_s_data = 32'h1000 + i;
      @(posedge i_clk); #1;
    end
    i_s_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    n_vec++;
    if (o_m_valid !== 1'b1 || o_m_data !== 32'h0 || o_m_last !== 1'b0 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL pad_zero_word: got mv=%0b data=%08h last=%0b busy=%0b, required 1 00000000 0 1",
                        o_m_valid, o_m_data, o_m_last, o_busy);
    end
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    n_vec++;
    if ({o_busy, o_done, o_err, o_m_valid, o_m_last, o_s_ready, o_blk_cnt} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_mid_pad: got busy=%0b mv=%0b ml=%0b sr=%0b blk=%0d, required all 0",
               o_busy, o_m_valid, o_m_last, o_s_ready, o_blk_cnt);
    end
    exp_q.delete();
    mon_en = 1'b1;
    frame_test("after_reset", 2'd2, 3'd0, 10'd33, 33, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_ct_k3_aligned();
    test_pk_k2();
    test_custom_33();
    test_stalls();
    test_reject();
    test_midframe_start();
    test_reset_in_pad();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
